pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed decode/execute stage register: a generic elastic pipeline stage carrying an opaque payload between any two stages.
- Adds a valid/ready handshake, an optional 2-entry skid buffer so full throughput survives downstream backpressure, and a preserve-mask so bubble/flush can keep selected fields (e.g. PC) while the rest becomes the NOP encoding.
- Adds saturating stall and bubble counters for performance monitoring.
- Sits between pipeline stages; the hazard unit drives stall/flush/bubble.

Parameters:
- WIDTH, 64, payload width in bits.
- NOP_VALUE, 0, WIDTH-bit payload loaded on reset, flush and bubble, for bits not selected by KEEP_MASK.
- KEEP_MASK, 0, WIDTH-bit mask; bits set to 1 retain the current out_data bit on flush and bubble.
- SKID, 1, 1 = 2-entry operation (output register plus skid register); 0 = single register, no skid.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- stall  in  1  freeze the whole stage.
- flush  in  1  kill all held and incoming payloads.
- bubble  in  1  insert one NOP into the output.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  registered payload.
- stall_cnt  out  CNT_WIDTH  cycles with stall=1.
- bubble_cnt  out  CNT_WIDTH  bubbles actually inserted.

Behaviour:
- Priority order: reset > stall > flush > bubble > normal.
- Definitions:
  - out_free = !out_valid | out_ready.
  - Transfer out = out_valid & out_ready & !stall.
  - Accept = in_valid & in_ready.
- Reset values: out_valid=0, out_data=NOP_VALUE, skid empty, stall_cnt=0, bubble_cnt=0.
- in_ready (combinational):
  - SKID=1: !skid_valid & !stall & !bubble & !flush.
  - SKID=0: out_free & !stall & !bubble & !flush.
- Stall:
  - out_data, out_valid and the skid are held; out_ready is ignored; no transfer.
  - stall_cnt increments, saturating at all-ones.
- Flush (stall=0):
  - out_data <= (out_data & KEEP_MASK) | (NOP_VALUE & ~KEEP_MASK); out_valid <= 0; skid cleared.
  - in_data is not accepted.
  - Flush with bubble in the same cycle is treated as flush only; bubble_cnt does not increment.
- Bubble (stall=0, flush=0):
  - If out_free: out_data <= masked NOP as for flush; out_valid <= 0; skid held; bubble_cnt increments (saturating).
  - If !out_free: no effect and no count; the hazard unit holds bubble until the bubble lands.
- Normal, when out_free:
  - If the skid is valid, the output loads the skid, skid_valid <= 0.
  - Else, if accept, the output loads in_data, out_valid <= 1.
  - Else out_valid <= 0 and out_data is held.
- Normal, when !out_free:
  - The output is held.
  - With SKID=1, an accept while the skid is empty writes the skid.
- Latency: 1 cycle from accept to out_valid when the skid is empty. Throughput is 1 per cycle under continuous out_ready.
- Ordering: strictly FIFO; the skid entry is always older than in_data.
- Counters: not cleared by flush; cleared only by reset.
- Reset mid-transfer: all contents are discarded; in_ready is low during the reset cycle.

Test Plan:
(Config for all scenarios: WIDTH=16, NOP_VALUE=16'h0013, KEEP_MASK=16'hFF00, SKID=1, CNT_WIDTH=4.)
- Streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later; out_valid continuous; in_ready stays 1.
- Backpressure/skid: out holds 16'hAA01, out_ready=0, push 16'hBB02 -> skid full, in_ready=0. Raise out_ready -> outputs AA01 then BB02, no loss or duplication.
- Bubble with keep: out_data=16'h1234 valid, out_ready=1, bubble=1 -> out_data=16'h1213, out_valid=0, bubble_cnt=1; an input offered that cycle is taken next cycle.
- Flush with skid full: out=16'h1111, skid=16'h2222, flush=1 -> out_data=16'h1113, out_valid=0, skid empty, 2222 never appears at the output.
- Stall dominance: stall=1 with flush=1 for 3 cycles -> out_data and skid unchanged, stall_cnt=3. Deassert stall with flush=1 -> flush applied.
- Saturation/reset: stall held for 20 cycles -> stall_cnt=15. Then reset=1 mid-skid -> next cycle all counters 0, out_data=16'h0013, out_valid=0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready payload register with an optional skid entry and masked NOP on flush/bubble.
// One cycle from accept to out_valid; stall freezes everything and flush/bubble close in_ready.
module pipe_stage_elastic #(
  parameter int unsigned        WIDTH     = 64,
  parameter logic [WIDTH-1:0]   NOP_VALUE = '0,
  parameter logic [WIDTH-1:0]   KEEP_MASK = '0,
  parameter bit                 SKID      = 1'b1,
  parameter int unsigned        CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 bubble,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic                 r_skid_valid;
  logic [WIDTH-1:0]     r_skid_data;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;

  logic                 w_out_free;
  logic                 w_space;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_nop_data;

  assign w_out_free = !r_out_valid || out_ready;
  // With a skid, acceptance only needs the skid slot; without, it needs the output slot.
  assign w_space    = SKID ? !r_skid_valid : w_out_free;
  assign in_ready   = w_space && !stall && !bubble && !flush && !reset;
  assign w_accept   = in_valid && in_ready;
  assign w_nop_data = (r_out_data & KEEP_MASK) | (NOP_VALUE & ~KEEP_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= NOP_VALUE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= NOP_VALUE;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (stall) begin
      if (r_stall_cnt != {CNT_WIDTH{1'b1}}) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end else if (flush) begin
      r_out_data   <= w_nop_data;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (bubble) begin
      // A bubble only lands once the output slot is free; until then the hazard unit keeps it asserted.
      if (w_out_free) begin
        r_out_data  <= w_nop_data;
        r_out_valid <= 1'b0;
        if (r_bubble_cnt != {CNT_WIDTH{1'b1}}) begin
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
      end
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (SKID && w_accept) begin
      r_skid_data  <= in_data;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a table of per-cycle inputs and hand-computed results,
// followed by a hand-written stall-saturation and reset-mid-skid sequence.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        stall;
  logic        flush;
  logic        bubble;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  stall_cnt;
  logic [3:0]  bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_elastic #(
    .WIDTH(16), .NOP_VALUE(16'h0013), .KEEP_MASK(16'hFF00), .SKID(1'b1), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .stall(stall), .flush(flush), .bubble(bubble), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld;
    logic [15:0] dat;
    logic        stl, fl, bub, ordy;
    logic        e_ir, e_ov;
    logic [15:0] e_od;
    logic [3:0]  e_sc, e_bc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, vld, input logic [15:0] dat, input logic stl, fl, bub, ordy,
                     input logic e_ir, e_ov, input logic [15:0] e_od, input logic [3:0] e_sc, e_bc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.stl = stl; v.fl = fl; v.bub = bub; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_sc = e_sc; v.e_bc = e_bc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rst, vld, input logic [15:0] dat, input logic stl, fl, bub, ordy);
    @(negedge clk);
    reset = rst; in_valid = vld; in_data = dat; stall = stl; flush = fl; bubble = bub; out_ready = ordy;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0; bubble = 1'b0; out_ready = 1'b0;

    //   rst vld dat      stl fl bub ordy | ir ov od       sc bc
    add(1, 0, 16'h0000, 0, 0, 0, 0,   0, 0, 16'h0013, 0, 0);
    // streaming
    add(0, 1, 16'h0001, 0, 0, 0, 1,   1, 1, 16'h0001, 0, 0);
    add(0, 1, 16'h0002, 0, 0, 0, 1,   1, 1, 16'h0002, 0, 0);
    add(0, 1, 16'h0003, 0, 0, 0, 1,   1, 1, 16'h0003, 0, 0);
    add(0, 1, 16'h0004, 0, 0, 0, 1,   1, 1, 16'h0004, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 16'h0004, 0, 0);
    // backpressure into skid, then drain in order
    add(0, 1, 16'hAA01, 0, 0, 0, 0,   1, 1, 16'hAA01, 0, 0);
    add(0, 1, 16'hBB02, 0, 0, 0, 0,   1, 1, 16'hAA01, 0, 0);
    add(0, 1, 16'hCC03, 0, 0, 0, 0,   0, 1, 16'hAA01, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 0, 1,   0, 1, 16'hBB02, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 16'hBB02, 0, 0);
    // bubble keeps high byte; offered input taken the following cycle
    add(0, 1, 16'h1234, 0, 0, 0, 1,   1, 1, 16'h1234, 0, 0);
    add(0, 1, 16'h5678, 0, 0, 1, 1,   0, 0, 16'h1213, 0, 1);
    add(0, 1, 16'h5678, 0, 0, 0, 1,   1, 1, 16'h5678, 0, 1);
    // bubble blocked while output is not free, lands once it is
    add(0, 0, 16'h0000, 0, 0, 1, 0,   0, 1, 16'h5678, 0, 1);
    add(0, 0, 16'h0000, 0, 0, 1, 1,   0, 0, 16'h5613, 0, 2);
    // flush with skid full
    add(0, 1, 16'h1111, 0, 0, 0, 0,   1, 1, 16'h1111, 0, 2);
    add(0, 1, 16'h2222, 0, 0, 0, 0,   1, 1, 16'h1111, 0, 2);
    add(0, 0, 16'h0000, 0, 1, 0, 0,   0, 0, 16'h1113, 0, 2);
    add(0, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 16'h1113, 0, 2);
    // stall dominates flush, then flush applies
    add(0, 1, 16'h3333, 0, 0, 0, 0,   1, 1, 16'h3333, 0, 2);
    add(0, 1, 16'h4444, 0, 0, 0, 0,   1, 1, 16'h3333, 0, 2);
    add(0, 0, 16'h0000, 1, 1, 0, 1,   0, 1, 16'h3333, 1, 2);
    add(0, 0, 16'h0000, 1, 1, 0, 1,   0, 1, 16'h3333, 2, 2);
    add(0, 0, 16'h0000, 1, 1, 0, 1,   0, 1, 16'h3333, 3, 2);
    add(0, 0, 16'h0000, 0, 1, 0, 1,   0, 0, 16'h3313, 3, 2);
    add(0, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 16'h3313, 3, 2);
    // flush with bubble: flush only, no bubble count
    add(0, 0, 16'h0000, 0, 1, 1, 1,   0, 0, 16'h3313, 3, 2);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].stl, vecs[i].fl, vecs[i].bub, vecs[i].ordy);
      check($sformatf("v%0d in_ready", i), {15'd0, in_ready}, {15'd0, vecs[i].e_ir});
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].e_ov});
      check($sformatf("v%0d out_data", i), out_data, vecs[i].e_od);
      check($sformatf("v%0d stall_cnt", i), {12'd0, stall_cnt}, {12'd0, vecs[i].e_sc});
      check($sformatf("v%0d bubble_cnt", i), {12'd0, bubble_cnt}, {12'd0, vecs[i].e_bc});
    end

    // fill output and skid, then stall for 20 cycles: counter saturates, contents frozen
    drive(0, 1, 16'h5555, 0, 0, 0, 0); @(posedge clk);
    drive(0, 1, 16'h6666, 0, 0, 0, 0); @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 16'h0000, 1, 0, 0, 1); @(posedge clk);
    end
    #1;
    check("sat stall_cnt", {12'd0, stall_cnt}, 16'h000F);
    check("sat out_data", out_data, 16'h5555);
    check("sat out_valid", {15'd0, out_valid}, 16'h0001);

    // reset while the skid holds 6666: everything discarded
    drive(1, 1, 16'h7777, 0, 0, 0, 1);
    check("rst in_ready", {15'd0, in_ready}, 16'h0000);
    @(posedge clk); #1;
    check("rst stall_cnt", {12'd0, stall_cnt}, 16'h0000);
    check("rst bubble_cnt", {12'd0, bubble_cnt}, 16'h0000);
    check("rst out_data", out_data, 16'h0013);
    check("rst out_valid", {15'd0, out_valid}, 16'h0000);
    drive(0, 0, 16'h0000, 0, 0, 0, 1);
    check("post-rst in_ready", {15'd0, in_ready}, 16'h0001);
    @(posedge clk); #1;
    check("post-rst out_valid", {15'd0, out_valid}, 16'h0000);
    check("post-rst out_data", out_data, 16'h0013);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
